demux_sched: RTL and testbench
==============================

# demux_sched

Burst scheduler for the 1-to-2 demux stage (two 8-bit lanes sharing one `selector`). It owns the shared `selector`, steering a configurable burst of words to destination side 0 (Salida0/Salida2) and then to side 1 (Salida1/Salida3). It throttles upstream through `ready` when the active side's downstream FIFO reports almost-full, and keeps per-side transfer counters for debug and verification.

## Interface
- `BURST`, default 4: burst length loaded at reset. Legal range 1..16; the low 4 bits are stored, and 0 encodes 16.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low. Low forces the reset state immediately; release is sampled on `clk`.
- `init`  in  1  configuration request; while high the block sits in INIT and loads `burst_len`.
- `burst_len`  in  4  words per burst, loaded during INIT; 0 means 16.
- `validEntrada0`  in  1  lane 0 upstream word valid.
- `validEntrada1`  in  1  lane 1 upstream word valid.
- `pause0`  in  1  almost-full from side-0 downstream FIFOs.
- `pause1`  in  1  almost-full from side-1 downstream FIFOs.
- `selector`  out  1  drives both demux selectors; 0 = side 0, 1 = side 1.
- `ready`  out  1  upstream may present words.
- `word_cnt`  out  4  words already sent in the current burst.
- `sent0`  out  8  total transfers steered to side 0; wraps 255 to 0.
- `sent1`  out  8  total transfers steered to side 1; wraps 255 to 0.
- `state`  out  3  INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, STALL=3'd4.

## Operation
- **Transfer**: any cycle with `ready`=1 and (`validEntrada0` | `validEntrada1`). Both lanes move together and count as one transfer.
- **Reset values**: `state`=INIT, `selector`=0, `ready`=0, `word_cnt`=0, `sent0`=`sent1`=0, burst register=`BURST`.
- **Next-state priority**, evaluated every edge:
  1. `init`=1 in any state → INIT.
  2. Otherwise, the state-specific rules below.
- **INIT**:
  - `ready`=0; `word_cnt`=0; `selector`=0.
  - Each cycle with `init`=1, the burst register loads `burst_len`.
  - `init`=0 → IDLE. Leaving INIT without any `init` pulse (i.e. after reset) keeps `BURST`.
- **IDLE / ACTIVE**:
  - `ready`=1.
  - On a transfer, `sent[selector]` increments and `word_cnt` increments.
  - If the incremented count equals the burst length (0 ≡ 16): `selector` toggles, `word_cnt`=0, next state is IDLE. Otherwise the next state is ACTIVE.
  - No transfer → state, `word_cnt` and `selector` hold (an open burst stays open indefinitely).
- **Pause check**: evaluated after the selector update of the same cycle. If `pause[sel_next]`=1, next state is STALL instead of IDLE/ACTIVE. The transfer of that cycle still counts.
- **STALL**:
  - `ready`=0; `word_cnt`, `selector`, `sent*` hold.
  - When `pause[selector]`=0: next state is IDLE if `word_cnt`=0, otherwise ACTIVE.
- **Ignored inputs**: the pause of the inactive side is ignored. Valid without `ready` is not a transfer and changes no state.
- **Counter clearing**: `sent0`/`sent1` are cleared only by `reset`, never by `init`.

## Timing
- `ready`, `selector` and `state` are registered or a pure decode of registered state; no combinational input-to-output path.
- **Pause latency**: `pause` high at edge N → `ready` low from cycle N+1. A transfer in cycle N is accepted, so downstream must tolerate one extra word after almost-full.
- **Burst switch**: `selector` changes on the edge that accepts the last word of a burst. The first word of the next burst may transfer in the very next cycle, so bursts run back-to-back with no bubble.
- **Init / reset during a burst**:
  - `init` mid-burst aborts the burst: next cycle INIT, `word_cnt`=0, `selector`=0.
  - `reset` low mid-burst clears all outputs asynchronously, without waiting for `clk`.
- **Wrap-around**: `sent*` roll over 255 → 0. `word_cnt` never exceeds burst length minus 1.

## Test plan
- **Reset**: assert `reset` low mid-burst (`word_cnt`=2, `selector`=1) → outputs immediately 0 and `state`=1. Release with `init`=0 → `state`=2 and `ready`=1 after one edge.
- **Burst of 3**: `init`=1 with `burst_len`=3 for one cycle, then continuous `validEntrada0`=1 → `selector` pattern 0,0,0,1,1,1,0. After 6 transfers `sent0`=3 and `sent1`=3.
- **Burst length 0**: `burst_len`=0 with continuous valid → `selector` toggles every 16 transfers; `word_cnt` reaches 15, then returns to 0.
- **Active-side pause**: `selector`=1, `word_cnt`=1, assert `pause1` → next cycle `state`=4 and `ready`=0, and `pause0` toggling has no effect. Deassert `pause1` → `state`=3, `word_cnt` still 1.
- **Pause on the new side at burst end**: `pause1`=1 on the cycle that completes a side-0 burst → that transfer counted, `selector`=1, `state`=4, `word_cnt`=0. Release `pause1` → `state`=2.
- **Init mid-burst and counter wrap**: `init` mid-burst → `state`=1, `word_cnt`=0, `selector`=0, while `sent0`/`sent1` keep their values. Then 256 transfers on side 0 (burst 16) → `sent0` wraps back to its prior value.

Source files
------------

// File: rtl/demux_sched_if.sv
// Handshake and debug bundle between the upstream/downstream lanes and demux_sched.
// Transfer rule: a word moves on any clock edge where ready=1 and validEntrada0|validEntrada1.
interface demux_sched_if;
  logic       init;
  logic [3:0] burst_len;
  logic       validEntrada0;
  logic       validEntrada1;
  logic       pause0;
  logic       pause1;
  logic       selector;
  logic       ready;
  logic [3:0] word_cnt;
  logic [7:0] sent0;
  logic [7:0] sent1;
  logic [2:0] state;

  modport master (
    output init, burst_len, validEntrada0, validEntrada1, pause0, pause1,
    input  selector, ready, word_cnt, sent0, sent1, state
  );

  modport slave (
    input  init, burst_len, validEntrada0, validEntrada1, pause0, pause1,
    output selector, ready, word_cnt, sent0, sent1, state
  );
endinterface

// File: rtl/demux_sched.sv
// Burst scheduler for the 1-to-2 demux: owns the shared selector, counts bursts,
// throttles upstream on the active side's almost-full and keeps per-side transfer counts.
module demux_sched #(
  parameter int unsigned BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  demux_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_STALL  = 3'd4
  } state_t;

  localparam logic [3:0] LP_BURST_RST = BURST[3:0];

  state_t     r_state,    w_state_nxt;
  logic       r_selector, w_selector_nxt;
  logic [3:0] r_word_cnt, w_word_cnt_nxt;
  logic [3:0] r_burst,    w_burst_nxt;
  logic [7:0] r_sent0,    w_sent0_nxt;
  logic [7:0] r_sent1,    w_sent1_nxt;

  logic       w_ready;
  logic       w_xfer;
  logic [3:0] w_cnt_inc;
  logic       w_burst_end;

  assign w_ready   = (r_state == ST_IDLE) || (r_state == ST_ACTIVE);
  assign w_xfer    = w_ready && (bus.validEntrada0 || bus.validEntrada1);
  assign w_cnt_inc = r_word_cnt + 4'd1;
  // A stored length of 0 means 16: the 4-bit increment of 15 wraps to 0 and matches.
  assign w_burst_end = (w_cnt_inc == r_burst);

  always_comb begin
    w_state_nxt    = r_state;
    w_selector_nxt = r_selector;
    w_word_cnt_nxt = r_word_cnt;
    w_burst_nxt    = r_burst;
    w_sent0_nxt    = r_sent0;
    w_sent1_nxt    = r_sent1;

    if (bus.init) begin
      w_state_nxt    = ST_INIT;
      w_selector_nxt = 1'b0;
      w_word_cnt_nxt = 4'd0;
      w_burst_nxt    = bus.burst_len;
    end else begin
      case (r_state)
        ST_INIT: begin
          w_state_nxt = ST_IDLE;
        end
        ST_IDLE, ST_ACTIVE: begin
          if (w_xfer) begin
            if (r_selector) w_sent1_nxt = r_sent1 + 8'd1;
            else            w_sent0_nxt = r_sent0 + 8'd1;
            if (w_burst_end) begin
              w_selector_nxt = ~r_selector;
              w_word_cnt_nxt = 4'd0;
              w_state_nxt    = ST_IDLE;
            end else begin
              w_word_cnt_nxt = w_cnt_inc;
              w_state_nxt    = ST_ACTIVE;
            end
          end
          // Pause is judged against the side that will be active next cycle.
          if (w_selector_nxt ? bus.pause1 : bus.pause0) begin
            w_state_nxt = ST_STALL;
          end
        end
        ST_STALL: begin
          if (!(r_selector ? bus.pause1 : bus.pause0)) begin
            w_state_nxt = (r_word_cnt == 4'd0) ? ST_IDLE : ST_ACTIVE;
          end
        end
        default: begin
          w_state_nxt = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_INIT;
      r_selector <= 1'b0;
      r_word_cnt <= 4'd0;
      r_burst    <= LP_BURST_RST;
      r_sent0    <= 8'd0;
      r_sent1    <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_selector <= w_selector_nxt;
      r_word_cnt <= w_word_cnt_nxt;
      r_burst    <= w_burst_nxt;
      r_sent0    <= w_sent0_nxt;
      r_sent1    <= w_sent1_nxt;
    end
  end

  assign bus.selector = r_selector;
  assign bus.ready    = w_ready;
  assign bus.word_cnt = r_word_cnt;
  assign bus.sent0    = r_sent0;
  assign bus.sent1    = r_sent1;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched: directed scenarios with hand-computed values plus random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_demux_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_sched_if bus();

  demux_sched #(.BURST(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: plain integers, burst length held as 1..16.
  int m_state;
  int m_sel;
  int m_cnt;
  int m_blen;
  int m_sent[2];

  logic [0:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic bit pause_of(input int side);
    return (side != 0) ? bus.pause1 : bus.pause0;
  endfunction

  task automatic model_reset();
    m_state   = 1;
    m_sel     = 0;
    m_cnt     = 0;
    m_blen    = 4;
    m_sent[0] = 0;
    m_sent[1] = 0;
  endtask

  task automatic model_step();
    if (bus.init) begin
      m_state = 1;
      m_cnt   = 0;
      m_sel   = 0;
      m_blen  = (bus.burst_len == 4'd0) ? 16 : int'(bus.burst_len);
    end else begin
      case (m_state)
        1: m_state = 2;
        2, 3: begin
          if (bus.validEntrada0 || bus.validEntrada1) begin
            m_sent[m_sel] = (m_sent[m_sel] + 1) % 256;
            m_cnt++;
            if (m_cnt == m_blen) begin
              m_sel   = 1 - m_sel;
              m_cnt   = 0;
              m_state = 2;
            end else begin
              m_state = 3;
            end
          end
          if (pause_of(m_sel)) m_state = 4;
        end
        4: if (!pause_of(m_sel)) m_state = (m_cnt == 0) ? 2 : 3;
        default: m_state = 1;
      endcase
    end
  endtask

  task automatic compare_all();
    check("state",    int'(bus.state),    m_state);
    check("ready",    int'(bus.ready),    int'(m_state == 2 || m_state == 3));
    check("selector", int'(bus.selector), m_sel);
    check("word_cnt", int'(bus.word_cnt), m_cnt);
    check("sent0",    int'(bus.sent0),    m_sent[0]);
    check("sent1",    int'(bus.sent1),    m_sent[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n             = 1'b1;
    bus.init          = 1'b0;
    bus.burst_len     = 4'd0;
    bus.validEntrada0 = 1'b0;
    bus.validEntrada1 = 1'b0;
    bus.pause0        = 1'b0;
    bus.pause1        = 1'b0;
    model_reset();

    // Power-on reset and release with init low
    #2;
    rst_n = 1'b0;
    #1;
    compare_all();
    check("rst_state", int'(bus.state), 1);
    check("rst_ready", int'(bus.ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rel_state", int'(bus.state), 2);
    check("rel_ready", int'(bus.ready), 1);

    // Burst of 3 with continuous valid
    bus.init      = 1'b1;
    bus.burst_len = 4'd3;
    tick();
    check("b3_init_state", int'(bus.state), 1);
    bus.init          = 1'b0;
    bus.validEntrada0 = 1'b1;
    tick();
    check("b3_idle_state", int'(bus.state), 2);
    exp_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      check("b3_sel_pattern", int'(bus.selector), int'(exp_q.pop_front()));
      tick();
      if (i == 5) begin
        check("b3_sent0", int'(bus.sent0), 3);
        check("b3_sent1", int'(bus.sent1), 3);
      end
    end

    // Active-side pause: reach selector=1, word_cnt=1
    repeat (3) tick();
    check("pz_sel", int'(bus.selector), 1);
    check("pz_cnt", int'(bus.word_cnt), 1);
    bus.validEntrada0 = 1'b0;
    bus.pause1        = 1'b1;
    tick();
    check("pz_stall", int'(bus.state), 4);
    check("pz_ready", int'(bus.ready), 0);
    for (int i = 0; i < 4; i++) begin
      bus.pause0 = ~bus.pause0;
      tick();
      check("pz_ignore_p0", int'(bus.state), 4);
    end
    bus.pause0 = 1'b0;
    bus.pause1 = 1'b0;
    tick();
    check("pz_resume_state", int'(bus.state), 3);
    check("pz_resume_cnt", int'(bus.word_cnt), 1);

    // Pause on the new side at the end of a side-0 burst
    bus.validEntrada0 = 1'b1;
    repeat (4) tick();
    bus.pause1 = 1'b1;
    tick();
    check("pe_sent0", int'(bus.sent0), 9);
    check("pe_sel", int'(bus.selector), 1);
    check("pe_state", int'(bus.state), 4);
    check("pe_cnt", int'(bus.word_cnt), 0);
    bus.validEntrada0 = 1'b0;
    bus.pause1        = 1'b0;
    tick();
    check("pe_release", int'(bus.state), 2);

    // Burst length 0 means 16
    bus.init      = 1'b1;
    bus.burst_len = 4'd0;
    tick();
    bus.init          = 1'b0;
    bus.validEntrada1 = 1'b1;
    tick();
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 15) begin
        check("b16_cnt15", int'(bus.word_cnt), 15);
        check("b16_sel_hold", int'(bus.selector), 0);
      end
      if (i == 16) begin
        check("b16_cnt_wrap", int'(bus.word_cnt), 0);
        check("b16_sel_toggle", int'(bus.selector), 1);
      end
      if (i == 32) check("b16_sel_back", int'(bus.selector), 0);
    end

    // Init mid-burst keeps the counters; then 256 side-0 transfers wrap sent0
    bus.init = 1'b1;
    tick();
    check("im_state", int'(bus.state), 1);
    check("im_cnt", int'(bus.word_cnt), 0);
    check("im_sel", int'(bus.selector), 0);
    check("im_sent0", int'(bus.sent0), 33);
    check("im_sent1", int'(bus.sent1), 22);
    bus.init          = 1'b0;
    bus.validEntrada1 = 1'b0;
    tick();
    bus.validEntrada0 = 1'b1;
    repeat (512) tick();
    check("wrap_sent0", int'(bus.sent0), 33);
    check("wrap_sent1", int'(bus.sent1), 22);

    // Asynchronous reset mid-burst at selector=1, word_cnt=2
    bus.init      = 1'b1;
    bus.burst_len = 4'd3;
    tick();
    bus.init = 1'b0;
    tick();
    repeat (5) tick();
    check("mr_pre_sel", int'(bus.selector), 1);
    check("mr_pre_cnt", int'(bus.word_cnt), 2);
    async_reset();
    check("mr_state", int'(bus.state), 1);
    check("mr_sel", int'(bus.selector), 0);
    check("mr_cnt", int'(bus.word_cnt), 0);
    check("mr_sent0", int'(bus.sent0), 0);
    bus.validEntrada0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mr_rel_state", int'(bus.state), 2);
    check("mr_rel_ready", int'(bus.ready), 1);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      bus.init          = ($urandom_range(0, 29) == 0);
      bus.burst_len     = 4'($urandom_range(0, 15));
      bus.validEntrada0 = ($urandom_range(0, 3) != 0);
      bus.validEntrada1 = ($urandom_range(0, 1) != 0);
      bus.pause0        = ($urandom_range(0, 4) == 0);
      bus.pause1        = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
